// File: rtl/alu_mul_sequencer_if.sv
// Handshake and ALU-borrowing bus between the core, the multiply sequencer and the shared ALU.
// The master is the core/ALU side and the slave is the sequencer.
interface alu_mul_sequencer_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_fun;
    logic [31:0] alu_result;

    modport master (
        output start, op_a, op_b, alu_result,
        input  busy, done, product, alu_a, alu_b, alu_fun
    );

    modport slave (
        input  start, op_a, op_b, alu_result,
        output busy, done, product, alu_a, alu_b, alu_fun
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply controller that drives the shared ALU for 32 iterations of add/shl/shr.
// It produces the low 32 bits of op_a*op_b.
module alu_mul_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    alu_mul_sequencer_if.slave bus
);
    localparam logic [3:0] FUN_ADD = 4'b0000;
    localparam logic [3:0] FUN_SLL = 4'b0001;
    localparam logic [3:0] FUN_SRL = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_SHL  = 3'd2,
        ST_SHR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] mcand_r;
    logic [31:0] mplier_r;
    logic [31:0] acc_r;
    logic [4:0]  cnt_r;
    logic [31:0] product_r;
    logic        busy_r;
    logic        done_r;

    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [3:0]  alu_fun_s;

    // Sequencer FSM: operand latch, per-phase capture of the ALU result, and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mcand_r   <= 32'd0;
            mplier_r  <= 32'd0;
            acc_r     <= 32'd0;
            cnt_r     <= 5'd0;
            product_r <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // The DONE cycle also accepts, which lets back-to-back multiplies run without an idle gap.
                    if (bus.start) begin
                        mcand_r  <= bus.op_a;
                        mplier_r <= bus.op_b;
                        acc_r    <= 32'd0;
                        cnt_r    <= 5'd0;
                        state_r  <= ST_ADD;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                    end else begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b0;
                    end
                end
                ST_ADD: begin
                    acc_r   <= bus.alu_result;
                    state_r <= ST_SHL;
                end
                ST_SHL: begin
                    mcand_r <= bus.alu_result;
                    state_r <= ST_SHR;
                end
                ST_SHR: begin
                    mplier_r <= bus.alu_result;
                    if (cnt_r == 5'd31) begin
                        state_r   <= ST_DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        product_r <= acc_r;
                    end else begin
                        cnt_r   <= cnt_r + 5'd1;
                        state_r <= ST_ADD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // ALU operand/function select, decoded from state and registers only so START never reaches the ALU.
    always_comb begin
        alu_a_s   = 32'd0;
        alu_b_s   = 32'd0;
        alu_fun_s = FUN_ADD;
        case (state_r)
            ST_ADD: begin
                alu_a_s   = acc_r;
                alu_b_s   = mplier_r[0] ? mcand_r : 32'd0;
                alu_fun_s = FUN_ADD;
            end
            ST_SHL: begin
                alu_a_s   = mcand_r;
                alu_b_s   = 32'd1;
                alu_fun_s = FUN_SLL;
            end
            ST_SHR: begin
                alu_a_s   = mplier_r;
                alu_b_s   = 32'd1;
                alu_fun_s = FUN_SRL;
            end
            default: begin
                alu_a_s   = 32'd0;
                alu_b_s   = 32'd0;
                alu_fun_s = FUN_ADD;
            end
        endcase
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign bus.alu_a   = alu_a_s;
    assign bus.alu_b   = alu_b_s;
    assign bus.alu_fun = alu_fun_s;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and random bench for alu_mul_sequencer with a behavioural ALU and plain-arithmetic product model.
module tb_alu_mul_sequencer;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    alu_mul_sequencer_if bus ();

    alu_mul_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU stand-in.
    always_comb begin
        bus.alu_result = 32'd0;
        case (bus.alu_fun)
            4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            4'b0101: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            default: bus.alu_result = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_fun(input int k);
        case (k % 3)
            0:       return 4'b0000;
            1:       return 4'b0001;
            default: return 4'b0101;
        endcase
    endfunction

    task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
    endtask

    // Watches one multiply from just after its accept edge until DONE (bounded), optionally raising START mid-run.
    task automatic finish_mul(input string tag, input logic [31:0] exp_prod, input int inject_after,
                              input bit hold, input logic [31:0] ia, input logic [31:0] ib);
        int nbusy;
        int nbad;
        int guard;
        nbusy = 0;
        nbad  = 0;
        guard = 0;
        while (guard < 200) begin
            @(negedge clk);
            guard++;
            if (bus.busy && bus.done) nbad++;
            if (bus.done) break;
            if (bus.busy) begin
                if (bus.alu_fun !== exp_fun(nbusy)) nbad++;
                nbusy++;
            end else begin
                nbad++;
            end
            if (nbusy == inject_after) begin
                bus.start = 1'b1;
                bus.op_a  = ia;
                bus.op_b  = ib;
            end else if (!hold) begin
                bus.start = 1'b0;
            end
        end
        check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check({tag, "_busy_cycles"}, nbusy, 32'd96);
        check({tag, "_seq_errors"}, nbad, 32'd0);
        check({tag, "_product"}, bus.product, exp_prod);
        check({tag, "_idle_alu"}, {bus.alu_a | bus.alu_b, 28'd0, bus.alu_fun} == 64'd0, 32'd1);
        if (!hold) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
            check({tag, "_held"}, bus.product, exp_prod);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          spurious;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op_a    = 32'd0;
        bus.op_b    = 32'd0;
        #3;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_product", bus.product, 32'd0);
        check("rst_alu_fun", {28'd0, bus.alu_fun}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        start_mul(32'd6, 32'd7);
        finish_mul("basic", 32'd42, -1, 1'b0, 32'd0, 32'd0);

        start_mul(32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_mul("wrap", 32'h00000001, -1, 1'b0, 32'd0, 32'd0);

        start_mul(32'h00010000, 32'h00010000);
        finish_mul("overflow", 32'h00000000, -1, 1'b0, 32'd0, 32'd0);

        start_mul(32'h12345678, 32'd0);
        finish_mul("zero_mplier", 32'd0, -1, 1'b0, 32'd0, 32'd0);

        start_mul(32'd3, 32'd5);
        finish_mul("busy_start", 32'd15, 10, 1'b0, 32'd100, 32'd100);

        // START held from the last busy cycle through the DONE cycle.
        start_mul(32'd3, 32'd5);
        finish_mul("b2b_first", 32'd15, 95, 1'b1, 32'd2, 32'd9);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_busy_rise", {31'd0, bus.busy}, 32'd1);
        finish_mul("b2b_second", 32'd18, -1, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) rb = 32'h80000001;
            start_mul(ra, rb);
            finish_mul("random", ra * rb, -1, 1'b0, 32'd0, 32'd0);
        end

        start_mul(32'd6, 32'd7);
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_product", bus.product, 32'd0);
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) spurious++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) spurious++;
        end
        check("midrst_quiet", spurious, 32'd0);
        @(posedge clk);
        #1;
        start_mul(32'd6, 32'd7);
        finish_mul("after_rst", 32'd42, -1, 1'b0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle multiply controller for the Otter MCU that borrows the shared ALU to compute the low 32 bits of a 32x32 product (RISC-V MUL semantics) by shift-and-add. It drives the ALU's A, B and ALU_FUN inputs and captures RESULT each cycle while busy. The core handshakes with it through START/BUSY/DONE. Outside a multiply, the datapath mux returns the ALU to the core.

## Interface
- FUN_ADD, 4'b0000, ALU_FUN code issued for accumulate
- FUN_SLL, 4'b0001, ALU_FUN code issued for multiplicand left shift
- FUN_SRL, 4'b0101, ALU_FUN code issued for multiplier right shift
- CLK  input  1  system clock; all state changes on rising edge
- RST_N  input  1  asynchronous, active-low reset
- START  input  1  request; sampled on rising CLK, accepted only when BUSY=0
- OP_A  input  32  multiplicand, latched at accept
- OP_B  input  32  multiplier, latched at accept
- BUSY  output  1  high while in ADD/SHL/SHR
- DONE  output  1  one-cycle pulse, PRODUCT valid
- PRODUCT  output  32  low 32 bits of OP_A*OP_B; held until next accept
- ALU_A  output  32  to ALU operand A
- ALU_B  output  32  to ALU operand B
- ALU_FUN  output  4  to ALU function select
- ALU_RESULT  input  32  from ALU RESULT (combinational)

## Operation
- Registers: MCAND[31:0], MPLIER[31:0], ACC[31:0], CNT[4:0], state.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE/DONE, START=1: MCAND<=OP_A, MPLIER<=OP_B, ACC<=0, CNT<=0, go ADD. Otherwise DONE->IDLE and IDLE holds.
- ADD: ALU_A=ACC, ALU_B=MPLIER[0] ? MCAND : 0, ALU_FUN=FUN_ADD; ACC<=ALU_RESULT; go SHL.
- SHL: ALU_A=MCAND, ALU_B=1, ALU_FUN=FUN_SLL; MCAND<=ALU_RESULT; go SHR.
- SHR: ALU_A=MPLIER, ALU_B=1, ALU_FUN=FUN_SRL; MPLIER<=ALU_RESULT. If CNT==31 go DONE, else CNT<=CNT+1 and go ADD.
- Entering DONE: PRODUCT<=ACC. PRODUCT changes only here and on reset.
- IDLE/DONE: ALU_A=0, ALU_B=0, ALU_FUN=FUN_ADD.
- All arithmetic is 32-bit modulo 2^32. Carries out of bit 31 are discarded. Sign is irrelevant to the low word, so there is no signed mode.
- No early termination. Every multiply runs all 32 iterations.

## Timing
- Reset (RST_N low, any time, asynchronous): state=IDLE, BUSY=0, DONE=0, PRODUCT=0, and MCAND/MPLIER/ACC/CNT=0.
- Reset mid-operation aborts the multiply. No DONE pulse is produced, and PRODUCT reads 0.
- Call edge E0 the edge where START is accepted.
  - BUSY is high from E0 through E96 (96 cycles).
  - The DONE state is entered at E96, so DONE=1 and the valid PRODUCT are visible for the single cycle between E96 and E97.
- START while BUSY=1 is ignored. It is not queued, and operands are not re-latched.
- START during the DONE cycle is accepted, which gives back-to-back operation. DONE still pulses for exactly one cycle, and the next multiply's BUSY rises at that same edge.
- ALU_A, ALU_B and ALU_FUN are combinational from state and registers only, never from START or OP_*. The ALU must settle within one cycle.
- DONE is never high together with BUSY.

## Test plan
- Basic multiply: reset, then START with OP_A=6, OP_B=7 → BUSY high for exactly 96 cycles, DONE pulses once, PRODUCT=42 and held afterward; ALU_FUN cycles 0000/0001/0101.
- Wrap-around: OP_A=32'hFFFFFFFF, OP_B=32'hFFFFFFFF → PRODUCT=32'h00000001.
- Overflow: OP_A=32'h00010000, OP_B=32'h00010000 → PRODUCT=32'h00000000.
- Zero multiplier: OP_B=0, OP_A=32'h12345678 → PRODUCT=0.
- Busy start ignored: START with 3,5, then 10 cycles later START with 100,100 → still 96 busy cycles from the first accept, PRODUCT=15.
- Back-to-back: START 3*5, then hold START=1 with OP_A=2, OP_B=9 through the DONE cycle → first DONE shows 15, second DONE 97 cycles later shows 18.
- Reset mid-operation: deassert RST_N 40 cycles into a 6*7 multiply → BUSY=0 and PRODUCT=0 immediately with no DONE; a fresh 6*7 then yields 42.
